// File: rtl/cpu_pkg.sv
// ---------------------------------------------------------------------------
// cpu_pkg
// Shared definitions for the multicycle CPU control path: opcode values,
// ALU operation codes, datapath mux select encodings and the controller
// state encoding. No ports; imported by opcode_decode and control_unit.
// ---------------------------------------------------------------------------
package cpu_pkg;

    localparam int OPCODE_W = 6;
    localparam int STATE_W  = 4;

    // R-type opcodes (R1 = R2 op R3)
    localparam logic [5:0] OP_NOP  = 6'b000000;
    localparam logic [5:0] OP_ADD  = 6'b000001;
    localparam logic [5:0] OP_SUB  = 6'b000010;
    localparam logic [5:0] OP_OR   = 6'b000011;
    localparam logic [5:0] OP_AND  = 6'b000100;
    localparam logic [5:0] OP_XOR  = 6'b000101;
    localparam logic [5:0] OP_NOT  = 6'b000110;
    localparam logic [5:0] OP_SLT  = 6'b000111;
    localparam logic [5:0] OP_MOV  = 6'b001000;

    // I-type opcodes
    localparam logic [5:0] OP_ADDI = 6'b010001;
    localparam logic [5:0] OP_SUBI = 6'b010010;
    localparam logic [5:0] OP_ORI  = 6'b010011;
    localparam logic [5:0] OP_ANDI = 6'b010100;
    localparam logic [5:0] OP_XORI = 6'b010101;
    localparam logic [5:0] OP_SLTI = 6'b010111;
    localparam logic [5:0] OP_LI   = 6'b011000;
    localparam logic [5:0] OP_LUI  = 6'b011001;
    localparam logic [5:0] OP_LWI  = 6'b011011;
    localparam logic [5:0] OP_SWI  = 6'b011100;

    // Control-flow opcodes
    localparam logic [5:0] OP_BEQ  = 6'b100000;
    localparam logic [5:0] OP_BNE  = 6'b100001;
    localparam logic [5:0] OP_J    = 6'b100010;
    localparam logic [5:0] OP_HALT = 6'b111111;

    // ALU operation codes
    localparam logic [3:0] ALU_PASSA = 4'b0000;
    localparam logic [3:0] ALU_ADD   = 4'b0001;
    localparam logic [3:0] ALU_SUB   = 4'b0010;
    localparam logic [3:0] ALU_OR    = 4'b0011;
    localparam logic [3:0] ALU_AND   = 4'b0100;
    localparam logic [3:0] ALU_XOR   = 4'b0101;
    localparam logic [3:0] ALU_NOT   = 4'b0110;
    localparam logic [3:0] ALU_SLT   = 4'b0111;
    localparam logic [3:0] ALU_PASSB = 4'b1000;

    // ALU operand B select
    localparam logic [1:0] ASB_REGB = 2'b00;
    localparam logic [1:0] ASB_ONE  = 2'b01;
    localparam logic [1:0] ASB_SE   = 2'b10;
    localparam logic [1:0] ASB_ZE   = 2'b11;

    // PC source select
    localparam logic [1:0] PCS_ALU    = 2'b00;
    localparam logic [1:0] PCS_ALUREG = 2'b01;
    localparam logic [1:0] PCS_JUMP   = 2'b10;
    localparam logic [1:0] PCS_SEIMM  = 2'b11;

    // Controller states
    typedef enum logic [3:0] {
        ST_RST    = 4'd0,
        ST_FETCH  = 4'd1,
        ST_DECODE = 4'd2,
        ST_EXEC_R = 4'd3,
        ST_EXEC_I = 4'd4,
        ST_ALU_WB = 4'd5,
        ST_MEM_RD = 4'd6,
        ST_MEM_WB = 4'd7,
        ST_MEM_WR = 4'd8,
        ST_BRANCH = 4'd9,
        ST_JUMP   = 4'd10,
        ST_HALT   = 4'd11
    } state_t;

endpackage

// File: rtl/opcode_decode.sv
// ---------------------------------------------------------------------------
// opcode_decode
// Combinational opcode classifier for the control unit.
// Ports:
//   opcode    in  OPW  instruction opcode field
//   is_rtype  out 1    register-register ALU op (ADD..MOV, excludes NOP)
//   is_itype  out 1    immediate ALU op, LI or LUI
//   uses_ze   out 1    immediate operand is zero-extended
//   is_load   out 1    LWI
//   is_store  out 1    SWI
//   is_branch out 1    BEQ / BNE
//   is_jump   out 1    J
//   is_halt   out 1    HALT or any unassigned opcode
//   alu_op    out 4    ALU operation used in the execute cycle
// NOP is the only opcode that raises none of the class flags.
// ---------------------------------------------------------------------------
module opcode_decode
    import cpu_pkg::*;
#(
    parameter int OPW = OPCODE_W
) (
    input  logic [OPW-1:0] opcode,
    output logic           is_rtype,
    output logic           is_itype,
    output logic           uses_ze,
    output logic           is_load,
    output logic           is_store,
    output logic           is_branch,
    output logic           is_jump,
    output logic           is_halt,
    output logic [3:0]     alu_op
);

    // Classify the opcode; arithmetic/logic opcodes carry their ALU code in bits [3:0]
    always_comb begin
        is_rtype  = 1'b0;
        is_itype  = 1'b0;
        uses_ze   = 1'b0;
        is_load   = 1'b0;
        is_store  = 1'b0;
        is_branch = 1'b0;
        is_jump   = 1'b0;
        is_halt   = 1'b0;
        alu_op    = ALU_PASSA;
        case (opcode)
            OP_NOP: begin
                alu_op = ALU_PASSA;
            end
            OP_ADD, OP_SUB, OP_OR, OP_AND, OP_XOR, OP_NOT, OP_SLT: begin
                is_rtype = 1'b1;
                alu_op   = opcode[3:0];
            end
            OP_MOV: begin
                // MOV's low opcode bits would read as PASSB; it copies operand A
                is_rtype = 1'b1;
                alu_op   = ALU_PASSA;
            end
            OP_ADDI, OP_SUBI, OP_SLTI: begin
                is_itype = 1'b1;
                alu_op   = opcode[3:0];
            end
            OP_ORI, OP_ANDI, OP_XORI: begin
                is_itype = 1'b1;
                uses_ze  = 1'b1;
                alu_op   = opcode[3:0];
            end
            OP_LI: begin
                is_itype = 1'b1;
                alu_op   = ALU_PASSB;
            end
            OP_LUI: begin
                is_itype = 1'b1;
                uses_ze  = 1'b1;
                alu_op   = ALU_PASSB;
            end
            OP_LWI: begin
                is_load = 1'b1;
            end
            OP_SWI: begin
                is_store = 1'b1;
            end
            OP_BEQ, OP_BNE: begin
                is_branch = 1'b1;
            end
            OP_J: begin
                is_jump = 1'b1;
            end
            default: begin
                // HALT and every unassigned opcode stop the machine
                is_halt = 1'b1;
            end
        endcase
    end

endmodule

// File: rtl/control_unit.sv
// ---------------------------------------------------------------------------
// control_unit
// Multicycle FSM controller for the CPU datapath. Sequences FETCH, DECODE,
// EXECUTE, MEMORY and WRITEBACK cycles from the instruction register opcode.
// Outputs are Moore-style: decoded from the state register plus the opcode,
// so asserting reset zeroes every control line without waiting for a clock.
// Ports:
//   clk        in  1    rising-edge clock
//   reset      in  1    asynchronous reset, active low
//   IReg_out   in  32   instruction register (opcode = [31:26])
//   PCWrite, MemRead, IRWrite, MemWrite, MemtoReg, ALUSrcA, RegWrite,
//   BranchType, LUI, SW           out 1 each datapath controls
//   PCSource   out 2    PC input select
//   ALUSrcB    out 2    ALU operand B select
//   ALUOp      out 4    ALU operation
//   halted     out 1    high while in HALT
//   state      out STW  current state (debug)
// ---------------------------------------------------------------------------
module control_unit
    import cpu_pkg::*;
#(
    parameter int OPW = OPCODE_W,
    parameter int STW = STATE_W
) (
    input  logic           clk,
    input  logic           reset,
    input  logic [31:0]    IReg_out,
    output logic           PCWrite,
    output logic           MemRead,
    output logic           IRWrite,
    output logic           MemWrite,
    output logic           MemtoReg,
    output logic           ALUSrcA,
    output logic           RegWrite,
    output logic           BranchType,
    output logic           LUI,
    output logic           SW,
    output logic [1:0]     PCSource,
    output logic [1:0]     ALUSrcB,
    output logic [3:0]     ALUOp,
    output logic           halted,
    output logic [STW-1:0] state
);

    state_t         state_r;
    state_t         next_state_s;
    logic [OPW-1:0] opcode_s;
    logic           is_rtype_s;
    logic           is_itype_s;
    logic           uses_ze_s;
    logic           is_load_s;
    logic           is_store_s;
    logic           is_branch_s;
    logic           is_jump_s;
    logic           is_halt_s;
    logic [3:0]     alu_op_s;
    logic           unused_ir_s;

    assign opcode_s    = IReg_out[31 -: OPW];
    // Operand fields belong to the datapath; the controller only looks at the opcode
    assign unused_ir_s = ^IReg_out[31-OPW:0];
    assign state       = STW'(state_r);

    opcode_decode #(
        .OPW (OPW)
    ) u_opcode_decode (
        .opcode    (opcode_s),
        .is_rtype  (is_rtype_s),
        .is_itype  (is_itype_s),
        .uses_ze   (uses_ze_s),
        .is_load   (is_load_s),
        .is_store  (is_store_s),
        .is_branch (is_branch_s),
        .is_jump   (is_jump_s),
        .is_halt   (is_halt_s),
        .alu_op    (alu_op_s)
    );

    // State register with asynchronous active-low reset
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r <= ST_RST;
        end else begin
            state_r <= next_state_s;
        end
    end

    // Next-state selection; DECODE dispatches on the opcode class
    always_comb begin
        next_state_s = state_r;
        case (state_r)
            ST_RST:    next_state_s = ST_FETCH;
            ST_FETCH:  next_state_s = ST_DECODE;
            ST_DECODE: begin
                if (is_halt_s) begin
                    next_state_s = ST_HALT;
                end else if (is_rtype_s) begin
                    next_state_s = ST_EXEC_R;
                end else if (is_itype_s) begin
                    next_state_s = ST_EXEC_I;
                end else if (is_load_s) begin
                    next_state_s = ST_MEM_RD;
                end else if (is_store_s) begin
                    next_state_s = ST_MEM_WR;
                end else if (is_branch_s) begin
                    next_state_s = ST_BRANCH;
                end else if (is_jump_s) begin
                    next_state_s = ST_JUMP;
                end else begin
                    // NOP: nothing to execute
                    next_state_s = ST_FETCH;
                end
            end
            ST_EXEC_R: next_state_s = ST_ALU_WB;
            ST_EXEC_I: next_state_s = ST_ALU_WB;
            ST_ALU_WB: next_state_s = ST_FETCH;
            ST_MEM_RD: next_state_s = ST_MEM_WB;
            ST_MEM_WB: next_state_s = ST_FETCH;
            ST_MEM_WR: next_state_s = ST_FETCH;
            ST_BRANCH: next_state_s = ST_FETCH;
            ST_JUMP:   next_state_s = ST_FETCH;
            ST_HALT:   next_state_s = ST_HALT;
            default:   next_state_s = ST_RST;
        endcase
    end

    // Moore output decode; every line defaults low and is raised per state
    always_comb begin
        PCWrite    = 1'b0;
        MemRead    = 1'b0;
        IRWrite    = 1'b0;
        MemWrite   = 1'b0;
        MemtoReg   = 1'b0;
        ALUSrcA    = 1'b0;
        RegWrite   = 1'b0;
        BranchType = 1'b0;
        LUI        = 1'b0;
        SW         = 1'b0;
        PCSource   = PCS_ALU;
        ALUSrcB    = ASB_REGB;
        ALUOp      = ALU_PASSA;
        halted     = 1'b0;
        case (state_r)
            ST_FETCH: begin
                MemRead  = 1'b1;
                IRWrite  = 1'b1;
                ALUSrcB  = ASB_ONE;
                ALUOp    = ALU_ADD;
                PCSource = PCS_ALU;
                PCWrite  = 1'b1;
            end
            ST_DECODE: begin
                // SW is raised early so register A reads R1 before the store
                SW = is_store_s;
            end
            ST_EXEC_R: begin
                ALUSrcA = 1'b1;
                ALUSrcB = ASB_REGB;
                ALUOp   = alu_op_s;
            end
            ST_EXEC_I: begin
                ALUSrcA = 1'b1;
                ALUSrcB = uses_ze_s ? ASB_ZE : ASB_SE;
                ALUOp   = alu_op_s;
            end
            ST_ALU_WB: begin
                RegWrite = 1'b1;
                LUI      = (opcode_s == OP_LUI);
            end
            ST_MEM_WB: begin
                RegWrite = 1'b1;
                MemtoReg = 1'b1;
            end
            ST_MEM_WR: begin
                MemWrite = 1'b1;
                SW       = 1'b1;
            end
            ST_BRANCH: begin
                // PC update is gated by the datapath's branch condition, not PCWrite
                PCSource   = PCS_SEIMM;
                BranchType = (opcode_s == OP_BNE);
            end
            ST_JUMP: begin
                PCSource = PCS_JUMP;
                PCWrite  = 1'b1;
            end
            ST_HALT: begin
                halted = 1'b1;
            end
            default: begin
                // RST and MEM_RD drive no controls
                halted = 1'b0;
            end
        endcase
    end

endmodule

// File: tb/tb_control_unit.sv
// ---------------------------------------------------------------------------
// tb_control_unit
// Directed and randomized instruction stream against a per-instruction
// reference schedule built from the instruction class.
// ---------------------------------------------------------------------------
module tb_control_unit;
    import cpu_pkg::*;

    logic        clk;
    logic        reset;
    logic [31:0] IReg_out;
    logic        PCWrite, MemRead, IRWrite, MemWrite, MemtoReg, ALUSrcA;
    logic        RegWrite, BranchType, LUI, SW, halted;
    logic [1:0]  PCSource, ALUSrcB;
    logic [3:0]  ALUOp;
    logic [3:0]  state;

    int total = 0;
    int bad   = 0;

    control_unit dut (
        .clk        (clk),
        .reset      (reset),
        .IReg_out   (IReg_out),
        .PCWrite    (PCWrite),
        .MemRead    (MemRead),
        .IRWrite    (IRWrite),
        .MemWrite   (MemWrite),
        .MemtoReg   (MemtoReg),
        .ALUSrcA    (ALUSrcA),
        .RegWrite   (RegWrite),
        .BranchType (BranchType),
        .LUI        (LUI),
        .SW         (SW),
        .PCSource   (PCSource),
        .ALUSrcB    (ALUSrcB),
        .ALUOp      (ALUOp),
        .halted     (halted),
        .state      (state)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL timeout");
        $fatal(1, "timeout");
    end

    // Output bundle: {PCWrite,MemRead,IRWrite,MemWrite,MemtoReg,ALUSrcA,RegWrite,
    //                 BranchType,LUI,SW,halted,PCSource,ALUSrcB,ALUOp}
    typedef logic [18:0] ovec_t;
    localparam ovec_t F_PCW = 19'h40000;
    localparam ovec_t F_MR  = 19'h20000;
    localparam ovec_t F_IRW = 19'h10000;
    localparam ovec_t F_MW  = 19'h08000;
    localparam ovec_t F_M2R = 19'h04000;
    localparam ovec_t F_ASA = 19'h02000;
    localparam ovec_t F_RW  = 19'h01000;
    localparam ovec_t F_BT  = 19'h00800;
    localparam ovec_t F_LUI = 19'h00400;
    localparam ovec_t F_SW  = 19'h00200;
    localparam ovec_t F_H   = 19'h00100;

    ovec_t obs;
    assign obs = {PCWrite, MemRead, IRWrite, MemWrite, MemtoReg, ALUSrcA, RegWrite,
                  BranchType, LUI, SW, halted, PCSource, ALUSrcB, ALUOp};

    localparam int C_NOP = 0, C_R = 1, C_I = 2, C_LD = 3, C_ST = 4, C_BR = 5, C_J = 6, C_HALT = 7;

    typedef struct {
        state_t st;
        ovec_t  ov;
    } step_t;
    step_t seq[$];

    logic [5:0] legal [22] = '{
        6'b000000, 6'b000001, 6'b000010, 6'b000011, 6'b000100, 6'b000101,
        6'b000110, 6'b000111, 6'b001000,
        6'b010001, 6'b010010, 6'b010011, 6'b010100, 6'b010101, 6'b010111,
        6'b011000, 6'b011001, 6'b011011, 6'b011100,
        6'b100000, 6'b100001, 6'b100010
    };

    function automatic int cls(input logic [5:0] op);
        case (op)
            6'b000000: return C_NOP;
            6'b000001, 6'b000010, 6'b000011, 6'b000100, 6'b000101,
            6'b000110, 6'b000111, 6'b001000: return C_R;
            6'b010001, 6'b010010, 6'b010011, 6'b010100, 6'b010101,
            6'b010111, 6'b011000, 6'b011001: return C_I;
            6'b011011: return C_LD;
            6'b011100: return C_ST;
            6'b100000, 6'b100001: return C_BR;
            6'b100010: return C_J;
            default:   return C_HALT;
        endcase
    endfunction

    // ALU operation by mnemonic
    function automatic logic [3:0] alu_ref(input logic [5:0] op);
        case (op)
            6'b000001, 6'b010001: return 4'd1;   // ADD, ADDI
            6'b000010, 6'b010010: return 4'd2;   // SUB, SUBI
            6'b000011, 6'b010011: return 4'd3;   // OR, ORI
            6'b000100, 6'b010100: return 4'd4;   // AND, ANDI
            6'b000101, 6'b010101: return 4'd5;   // XOR, XORI
            6'b000110:            return 4'd6;   // NOT
            6'b000111, 6'b010111: return 4'd7;   // SLT, SLTI
            6'b011000, 6'b011001: return 4'd8;   // LI, LUI
            default:              return 4'd0;   // MOV and the rest
        endcase
    endfunction

    function automatic logic zext_ref(input logic [5:0] op);
        return (op == 6'b010011) || (op == 6'b010100) || (op == 6'b010101) || (op == 6'b011001);
    endfunction

    function automatic step_t stp(input state_t s, input ovec_t v);
        step_t r;
        r.st = s;
        r.ov = v;
        return r;
    endfunction

    task automatic build_seq(input logic [5:0] op, input int halt_cycles);
        seq.delete();
        seq.push_back(stp(ST_FETCH, F_PCW | F_MR | F_IRW | ovec_t'({2'b00, 2'b01, 4'b0001})));
        seq.push_back(stp(ST_DECODE, (op == 6'b011100) ? F_SW : '0));
        case (cls(op))
            C_R: begin
                seq.push_back(stp(ST_EXEC_R, F_ASA | ovec_t'({2'b00, 2'b00, alu_ref(op)})));
                seq.push_back(stp(ST_ALU_WB, F_RW));
            end
            C_I: begin
                seq.push_back(stp(ST_EXEC_I, F_ASA |
                    ovec_t'({2'b00, (zext_ref(op) ? 2'b11 : 2'b10), alu_ref(op)})));
                seq.push_back(stp(ST_ALU_WB, F_RW | ((op == 6'b011001) ? F_LUI : '0)));
            end
            C_LD: begin
                seq.push_back(stp(ST_MEM_RD, '0));
                seq.push_back(stp(ST_MEM_WB, F_RW | F_M2R));
            end
            C_ST: seq.push_back(stp(ST_MEM_WR, F_MW | F_SW));
            C_BR: seq.push_back(stp(ST_BRANCH, ((op == 6'b100001) ? F_BT : '0) |
                                    ovec_t'({2'b11, 2'b00, 4'b0000})));
            C_J:  seq.push_back(stp(ST_JUMP, F_PCW | ovec_t'({2'b10, 2'b00, 4'b0000})));
            C_HALT: begin
                for (int k = 0; k < halt_cycles; k++) begin
                    seq.push_back(stp(ST_HALT, F_H));
                end
            end
            default: ;
        endcase
    endtask

    task automatic chk_state(input string tag, input state_t exp);
        total++;
        assert (state === exp) else begin
            bad++;
            $error("FAIL %s state obs=%0d exp=%0d", tag, state, exp);
        end
    endtask

    task automatic chk_out(input string tag, input ovec_t exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s outputs obs=%b exp=%b", tag, obs, exp);
        end
    endtask

    task automatic chk_cnt(input string tag, input int o, input int e);
        total++;
        assert (o === e) else begin
            bad++;
            $error("FAIL %s count obs=%0d exp=%0d", tag, o, e);
        end
    endtask

    // Called just after a negedge; leaves the time 1 unit past the edge entering FETCH
    task automatic do_reset(input string tag);
        reset = 1'b0;
        #1;
        chk_state({tag, " async"}, ST_RST);
        chk_out({tag, " async"}, '0);
        @(posedge clk);
        @(negedge clk);
        chk_state({tag, " held"}, ST_RST);
        chk_out({tag, " held"}, '0);
        reset = 1'b1;
        @(posedge clk);
        #1;
        chk_state({tag, " release"}, ST_FETCH);
    endtask

    // Starts 1 unit past the edge entering FETCH
    task automatic run_instr(input logic [31:0] instr, input int halt_cycles,
                             input int abort_at, input string tag);
        int n_pcw;
        int n_rw;
        int n_mw;
        int c;
        IReg_out = instr;
        build_seq(instr[31:26], halt_cycles);
        n_pcw = 0;
        n_rw  = 0;
        n_mw  = 0;
        for (int i = 0; i < seq.size(); i++) begin
            @(negedge clk);
            chk_state(tag, seq[i].st);
            chk_out(tag, seq[i].ov);
            n_pcw += int'(PCWrite);
            n_rw  += int'(RegWrite);
            n_mw  += int'(MemWrite);
            if (i == abort_at) begin
                #2;
                do_reset({tag, " abort"});
                return;
            end
        end
        c = cls(instr[31:26]);
        if (c != C_HALT) begin
            chk_cnt({tag, " pcwrite"}, n_pcw, (c == C_J) ? 2 : 1);
            chk_cnt({tag, " regwrite"}, n_rw, (c == C_R || c == C_I || c == C_LD) ? 1 : 0);
            chk_cnt({tag, " memwrite"}, n_mw, (c == C_ST) ? 1 : 0);
            @(posedge clk);
            #1;
            chk_state({tag, " end"}, ST_FETCH);
        end
    endtask

    initial begin
        logic [5:0] op;
        reset    = 1'b1;
        IReg_out = 32'h0000_0000;
        #1;
        reset = 1'b0;
        #2;
        chk_state("por", ST_RST);
        chk_out("por", '0);
        @(negedge clk);
        chk_state("por held", ST_RST);
        reset = 1'b1;
        @(posedge clk);
        #1;
        chk_state("por release", ST_FETCH);

        // Directed instructions
        run_instr(32'h0422_1800, 0, -1, "add");
        run_instr({6'b010011, 26'h0123456}, 0, -1, "ori");
        run_instr({6'b011001, 26'h3ABCDEF}, 0, -1, "lui");
        run_instr({6'b011011, 26'h0000010}, 0, -1, "lwi");
        run_instr({6'b011100, 26'h0000020}, 0, -1, "swi");
        run_instr({6'b100001, 26'h1555555}, 0, -1, "bne");
        run_instr({6'b100000, 26'h2AAAAAA}, 0, -1, "beq");
        run_instr({6'b100010, 26'h0000040}, 0, -1, "j");
        run_instr({6'b000000, 26'h3FFFFFF}, 0, -1, "nop");
        run_instr({6'b001000, 26'h0000000}, 0, -1, "mov");

        // Reset landing in EXEC_I between clock edges
        run_instr({6'b010001, 26'h0000007}, 0, 2, "addi");
        run_instr({6'b011000, 26'h0000009}, 0, -1, "li");

        // Random legal instruction stream
        for (int k = 0; k < 60; k++) begin
            op = legal[$urandom_range(0, 21)];
            run_instr({op, 26'($urandom)}, 0, -1, "rand");
        end

        // Illegal opcode halts; held for 20 cycles with the IR changing underneath
        run_instr({6'b110000, 26'h0000000}, 20, -1, "illegal");
        IReg_out = 32'h0422_1800;
        @(negedge clk);
        chk_state("halt hold", ST_HALT);
        chk_out("halt hold", F_H);
        do_reset("halt exit");

        run_instr({6'b111111, 26'($urandom)}, 3, -1, "halt");
        do_reset("halt2 exit");
        run_instr({6'b010110, 26'($urandom)}, 2, -1, "illegal2");
        do_reset("illegal2 exit");
        run_instr({6'b000011, 26'($urandom)}, 0, -1, "or");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
